st_rr_arbiter: RTL and testbench
================================

# st_rr_arbiter

Packet-locked round-robin arbiter that shares one 256-bit Avalon-ST sink among `NUM_SRC` streaming sources. Once a source is granted, it holds the output until its `last` beat transfers, so packets are never interleaved. A one-deep output register with full valid/ready backpressure sits between the mux and the downstream sink; the downstream is typically `test_st_sink` or a DMA write path.

## Interface
- `DATA_WIDTH`, 256: beat width in bits.
- `NUM_SRC`, 4: number of requesting sources, 1..16.
- `SRC_W`, `$clog2(NUM_SRC)` (minimum 1): width of the source index; derived, not overridden.
- `clk` in 1: single clock.
- `rst` in 1: synchronous, active-high reset.
- `in_data` in `NUM_SRC*DATA_WIDTH`: flattened source beats; source `i` occupies `[i*DATA_WIDTH +: DATA_WIDTH]`.
- `in_valid` in `NUM_SRC`: per-source beat valid.
- `in_last` in `NUM_SRC`: per-source end-of-packet flag, qualified by `in_valid`.
- `in_ready` out `NUM_SRC`: per-source ready; at most one bit high in any cycle.
- `out_data` out `DATA_WIDTH`: registered beat.
- `out_valid` out 1: registered beat valid.
- `out_last` out 1: registered end-of-packet flag.
- `out_src` out `SRC_W`: index of the source that produced `out_data`.
- `out_ready` in 1: downstream ready.
- `busy` out 1: high while in `LOCKED`.

## Operation
- FSM states:
  - `IDLE`: no grant held.
    - If any `in_valid` bit is high, select the first requester scanning upward from `ptr+1` modulo `NUM_SRC`.
    - Register the selection as `grant` and go to `LOCKED`.
    - If no request is present, stay in `IDLE`.
  - `LOCKED`:
    - `in_ready[grant] = !out_valid || out_ready`. All other `in_ready` bits are 0.
    - Transfer condition: `in_valid[grant] && in_ready[grant]`.
    - On a transfer, load `out_data` and `out_last` from the granted source, set `out_src` to `grant`, and set `out_valid`.
    - If `in_last[grant]` is high on the transfer, load `ptr` with `grant` and go to `IDLE`.
- Output register:
  - `out_valid` clears when `out_ready` is high and no new beat is loaded in the same cycle.
  - `out_data`, `out_last` and `out_src` hold stable while `out_valid && !out_ready`.
- Arbitration looks only at `in_valid`; `in_last` is ignored while in `IDLE`.
- Reset values:
  - State `IDLE`, `ptr = NUM_SRC-1` (source 0 wins first), `grant = 0`.
  - `out_valid = 0`, `out_data = 0`, `out_last = 0`, `out_src = 0`.
  - `in_ready = 0`, `busy = 0`.

## Timing
- Request to grant: a request seen in `IDLE` in cycle N produces `LOCKED` in cycle N+1. The first beat can transfer in cycle N+1.
- Beat latency: a beat transferred in cycle M appears with `out_valid` high in cycle M+1.
- Throughput: one beat per cycle within a packet. There is exactly one bubble cycle between packets, for the `IDLE` arbitration.
- Single-beat packet: `valid` and `last` on the first beat give a `LOCKED` → `IDLE` transition after one transfer.
- Granted source drops `in_valid` mid-packet: the arbiter stays `LOCKED` indefinitely; other sources stay blocked.
- `out_ready` held low: at most one beat is buffered and `in_ready` stays 0.
- Simultaneous `out_ready` high and a new transfer: the register reloads in the same cycle and `out_valid` stays 1.
- A source that deasserts `in_valid` in the arbitration cycle is still granted; it then waits in `LOCKED`.
- Reset mid-packet: any buffered beat is dropped and the FSM returns to `IDLE` with `ptr = NUM_SRC-1`. No partial-packet recovery.
- `NUM_SRC = 1`: `grant` is always 0; the bubble between packets still applies.

## Structure
- Package `st_arb_pkg`:
  - `typedef enum logic {IDLE, LOCKED} arb_state_t`.
  - Function `src_w(n)` returning `max(1, $clog2(n))`.
- Sub-module `st_rr_pick`: combinational rotate-priority picker.
  - Inputs: `req[NUM_SRC]`, `ptr`.
  - Outputs: `sel` index and `any`.
- Instantiate `st_rr_pick` once in `st_rr_arbiter`. It is reusable by future memory-port arbiters.

## Test plan
- **Reset:** assert `rst` 2 cycles with all `in_valid=1`. All outputs are 0 during reset; the first grant after release goes to source 0, and `out_src=0` appears 2 cycles after the `IDLE` cycle.
- **Fairness:** all 4 sources continuously send 3-beat packets with `out_ready=1`. `out_src` sequence is 0,0,0,1,1,1,2,2,2,3,3,3,0…, with one idle cycle between packets; no interleaving.
- **Backpressure:** source 2 sends data 0xA..0xD with `last` on 0xD; `out_ready` toggles 1,0,0,1,1. `out_data` is held stable while stalled, no beat is lost or duplicated, and `in_ready[2]` is low only while the register is full and stalled.
- **Stall mid-packet:** source 1 granted drops `in_valid` for 5 cycles mid-packet while source 3 requests. `busy` stays 1, `in_ready[3]` stays 0, and source 1 finishes before source 3 is granted.
- **Single-beat packets:** sources 0 and 3 alternate 1-beat packets (`valid` and `last` together). Output alternates 0,3,0,3 at one beat per 2 cycles.
- **Reset mid-packet:** assert `rst` one cycle during beat 2 of a 4-beat packet from source 1. `out_valid=0` next cycle, and a pending source-2 request is then granted first.

Source files
------------

// File: rtl/st_arb_pkg.sv
// Shared types and helpers for the streaming round-robin arbiter family.
package st_arb_pkg;

  typedef enum logic {IDLE, LOCKED} arb_state_t;

  // Index width for n sources; never narrower than one bit.
  function automatic int src_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/st_rr_pick.sv
// Combinational rotate-priority picker: first set request at or after ptr+1, wrapping.
module st_rr_pick
  import st_arb_pkg::*;
#(
  parameter  int NUM_SRC = 4,
  localparam int SRC_W   = src_w(NUM_SRC)
) (
  input  logic [NUM_SRC-1:0] req,
  input  logic [SRC_W-1:0]   ptr,
  output logic [SRC_W-1:0]   sel,
  output logic               any
);

  logic [SRC_W-1:0] cand;

  // Scan from the farthest offset down to ptr+1 so the nearest requester wins last.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    sel  = '0;
    any  = 1'b0;
    cand = '0;
    for (int i = NUM_SRC; i >= 1; i--) begin
      cand = SRC_W'((int'(ptr) + i) % NUM_SRC);
      if (req[cand]) begin
        sel = cand;
        any = 1'b1;
      end
    end
  end

endmodule

// File: rtl/st_rr_arbiter.sv
// Packet-locked round-robin arbiter sharing one streaming sink among NUM_SRC sources,
// with a one-deep registered output stage under full valid/ready backpressure.
module st_rr_arbiter
  import st_arb_pkg::*;
#(
  parameter  int DATA_WIDTH = 256,
  parameter  int NUM_SRC    = 4,
  localparam int SRC_W      = src_w(NUM_SRC)
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_SRC*DATA_WIDTH-1:0] in_data,
  input  logic [NUM_SRC-1:0]            in_valid,
  input  logic [NUM_SRC-1:0]            in_last,
  output logic [NUM_SRC-1:0]            in_ready,
  output logic [DATA_WIDTH-1:0]         out_data,
  output logic                          out_valid,
  output logic                          out_last,
  output logic [SRC_W-1:0]              out_src,
  input  logic                          out_ready,
  output logic                          busy
);

  arb_state_t            state, state_nxt;
  logic [SRC_W-1:0]      ptr, ptr_nxt;
  logic [SRC_W-1:0]      grant, grant_nxt;
  logic [SRC_W-1:0]      pick_sel;
  logic                  pick_any;
  logic                  slot_free;
  logic                  xfer;
  logic [DATA_WIDTH-1:0] src_data [NUM_SRC];

  for (genvar g = 0; g < NUM_SRC; g++) begin : g_unpack
    assign src_data[g] = in_data[g*DATA_WIDTH +: DATA_WIDTH];
  end

  st_rr_pick #(.NUM_SRC(NUM_SRC)) u_pick (
    .req (in_valid),
    .ptr (ptr),
    .sel (pick_sel),
    .any (pick_any)
  );

  // The output slot can take a beat when empty or when it drains this cycle.
  assign slot_free = !out_valid || out_ready;
  assign busy      = (state == LOCKED);
  assign xfer      = busy && slot_free && in_valid[grant];

  always_comb begin
    state_nxt = state;
    ptr_nxt   = ptr;
    grant_nxt = grant;
    in_ready  = '0;
    case (state)
      IDLE: begin
        if (pick_any) begin
          grant_nxt = pick_sel;
          state_nxt = LOCKED;
        end
      end
      LOCKED: begin
        in_ready[grant] = slot_free;
        if (xfer && in_last[grant]) begin
          ptr_nxt   = grant;
          state_nxt = IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    if (rst) begin
      state <= IDLE;
      ptr   <= SRC_W'(NUM_SRC - 1);
      grant <= '0;
    end else begin
      state <= state_nxt;
      ptr   <= ptr_nxt;
      grant <= grant_nxt;
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: the wide data register is reset too, so out_data reads zero after reset.
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_last  <= 1'b0;
      out_src   <= '0;
    end else if (xfer) begin
      out_valid <= 1'b1;
      out_data  <= src_data[grant];
      out_last  <= in_last[grant];
      out_src   <= grant;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_st_rr_arbiter.sv
// Self-checking bench for st_rr_arbiter: queue-driven sources, scoreboard on the output.
module tb_st_rr_arbiter;

  localparam int DW    = 256;
  localparam int NS    = 4;
  localparam int SW    = 2;
  localparam int DEPTH = 64;

  typedef struct packed {
    logic [DW-1:0] data;
    logic          last;
    logic [3:0]    src;
  } exp_t;

  logic              clk;
  logic              rst;
  logic [NS*DW-1:0]  in_data;
  logic [NS-1:0]     in_valid;
  logic [NS-1:0]     in_last;
  logic [NS-1:0]     in_ready;
  logic [DW-1:0]     out_data;
  logic              out_valid;
  logic              out_last;
  logic [SW-1:0]     out_src;
  logic              out_ready;
  logic              busy;

  int n_tests;
  int n_fail;
  int cyc;

  logic [DW-1:0] q_data [NS][DEPTH];
  logic          q_last [NS][DEPTH];
  int            q_head [NS];
  int            q_tail [NS];
  logic [NS-1:0] hold;

  exp_t sb[$];
  int   log_src[$];
  int   log_cyc[$];

  logic [NS-1:0] s_in_ready;
  logic          s_busy;
  logic          s_out_valid;
  logic [DW-1:0] s_out_data;

  st_rr_arbiter #(.DATA_WIDTH(DW), .NUM_SRC(NS)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_last   (in_last),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_last  (out_last),
    .out_src   (out_src),
    .out_ready (out_ready),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic clear_queues();
    for (int i = 0; i < NS; i++) begin
      q_head[i] = 0;
      q_tail[i] = 0;
    end
    hold = '0;
    sb.delete();
    log_src.delete();
    log_cyc.delete();
  endtask

  task automatic push_beat(input int s, input logic [DW-1:0] d, input logic l);
    q_data[s][q_tail[s]] = d;
    q_last[s][q_tail[s]] = l;
    q_tail[s]++;
  endtask

  task automatic push_pkt(input int s, input int len);
    logic [DW-1:0] d;
    for (int b = 0; b < len; b++) begin
      for (int w = 0; w < DW/32; w++) d[w*32 +: 32] = $urandom();
      d[7:0]  = 8'(s);
      d[15:8] = 8'(b);
      push_beat(s, d, b == len - 1);
    end
  endtask

  function automatic logic pending();
    logic p;
    p = 1'b0;
    for (int i = 0; i < NS; i++) if (q_head[i] < q_tail[i]) p = 1'b1;
    return p;
  endfunction

  // One clock: drive at negedge, sample and score output, then retire accepted beats.
  task automatic step();
    logic [NS-1:0] acc;
    exp_t e;
    @(negedge clk);
    for (int i = 0; i < NS; i++) begin
      if (q_head[i] < q_tail[i] && !hold[i]) begin
        in_valid[i]          = 1'b1;
        in_data[i*DW +: DW]  = q_data[i][q_head[i]];
        in_last[i]           = q_last[i][q_head[i]];
      end else begin
        in_valid[i]          = 1'b0;
        in_data[i*DW +: DW]  = '0;
        in_last[i]           = 1'b0;
      end
    end
    #1;
    s_in_ready  = in_ready;
    s_busy      = busy;
    s_out_valid = out_valid;
    s_out_data  = out_data;
    acc         = in_valid & in_ready;
    if (!rst) check("in_ready_onehot", DW'($countones(in_ready) <= 1), DW'(1));
    if (out_valid && out_ready) begin
      check("beat_expected", DW'(sb.size() > 0), DW'(1));
      if (sb.size() > 0) begin
        e = sb.pop_front();
        check("out_data", out_data, e.data);
        check("out_last", DW'(out_last), DW'(e.last));
        check("out_src", DW'(out_src), DW'(e.src));
      end
      log_src.push_back(int'(out_src));
      log_cyc.push_back(cyc);
    end
    @(posedge clk);
    cyc++;
    #1;
    if (rst) begin
      sb.delete();
    end else begin
      for (int i = 0; i < NS; i++) begin
        if (acc[i]) begin
          e.data = q_data[i][q_head[i]];
          e.last = q_last[i][q_head[i]];
          e.src  = 4'(i);
          sb.push_back(e);
          q_head[i]++;
        end
      end
    end
  endtask

  task automatic do_reset(input int n);
    rst = 1'b1;
    clear_queues();
    repeat (n) step();
    rst = 1'b0;
  endtask

  task automatic drain(input string tag, input int max_cyc);
    int k;
    k = 0;
    while ((pending() || sb.size() > 0 || out_valid) && k < max_cyc) begin
      step();
      k++;
    end
    check(tag, DW'(k < max_cyc), DW'(1));
    check({tag, "_sb_empty"}, DW'(sb.size()), DW'(0));
  endtask

  function automatic int log_at(input int k);
    return (k < log_src.size()) ? log_src[k] : -1;
  endfunction

  initial begin
    int bp_or [8];
    int bp_ir [8];
    int mark;
    n_tests   = 0;
    n_fail    = 0;
    cyc       = 0;
    in_data   = '0;
    in_valid  = '0;
    in_last   = '0;
    out_ready = 1'b1;
    rst       = 1'b1;
    clear_queues();

    // Reset with every source requesting, then first grant to source 0.
    for (int s = 0; s < NS; s++) push_pkt(s, 1);
    repeat (2) begin
      step();
      check("rst_out_valid", DW'(out_valid), DW'(0));
      check("rst_out_data",  out_data,       DW'(0));
      check("rst_out_last",  DW'(out_last),  DW'(0));
      check("rst_out_src",   DW'(out_src),   DW'(0));
      check("rst_in_ready",  DW'(in_ready),  DW'(0));
      check("rst_busy",      DW'(busy),      DW'(0));
    end
    rst = 1'b0;
    step();
    check("rst_idle_cycle_busy", DW'(s_busy), DW'(0));
    check("rst_locked_after_idle", DW'(busy), DW'(1));
    step();
    check("rst_first_out_valid", DW'(out_valid), DW'(1));
    check("rst_first_out_src", DW'(out_src), DW'(0));
    drain("rst_drain", 100);
    check("rst_order_len", DW'(log_src.size()), DW'(4));
    for (int k = 0; k < 4; k++) check("rst_order", DW'(log_at(k)), DW'(k));

    // Fairness: two rounds of 3-beat packets from every source, sink always ready.
    do_reset(2);
    for (int r = 0; r < 2; r++) for (int s = 0; s < NS; s++) push_pkt(s, 3);
    drain("fair_drain", 400);
    check("fair_len", DW'(log_src.size()), DW'(24));
    for (int k = 0; k < 24; k++) begin
      check("fair_src", DW'(log_at(k)), DW'((k / 3) % NS));
      if (k > 0 && k < log_cyc.size())
        check("fair_gap", DW'(log_cyc[k] - log_cyc[k-1]), DW'((k % 3 == 0) ? 2 : 1));
    end

    // Backpressure: source 2 sends 0xA..0xD while out_ready toggles.
    do_reset(2);
    push_beat(2, DW'(32'hA), 1'b0);
    push_beat(2, DW'(32'hB), 1'b0);
    push_beat(2, DW'(32'hC), 1'b0);
    push_beat(2, DW'(32'hD), 1'b1);
    bp_or = '{1, 1, 0, 0, 1, 1, 1, 1};
    bp_ir = '{0, 1, 0, 0, 1, 1, 1, 0};
    for (int s = 0; s < 8; s++) begin
      out_ready = (bp_or[s] != 0);
      step();
      check("bp_in_ready2", DW'(s_in_ready[2]), DW'(bp_ir[s]));
      if (s == 2 || s == 3) begin
        check("bp_hold_valid", DW'(s_out_valid), DW'(1));
        check("bp_hold_data", s_out_data, DW'(32'hA));
      end
    end
    out_ready = 1'b1;
    drain("bp_drain", 50);
    check("bp_beats", DW'(log_src.size()), DW'(4));

    // Granted source 1 stalls mid-packet while source 3 waits.
    do_reset(2);
    push_pkt(1, 6);
    push_pkt(3, 2);
    repeat (3) step();
    hold[1] = 1'b1;
    repeat (5) begin
      step();
      check("stall_busy", DW'(s_busy), DW'(1));
      check("stall_in_ready3", DW'(s_in_ready[3]), DW'(0));
    end
    hold = '0;
    drain("stall_drain", 100);
    check("stall_len", DW'(log_src.size()), DW'(8));
    for (int k = 0; k < 8; k++) check("stall_order", DW'(log_at(k)), DW'((k < 6) ? 1 : 3));

    // Single-beat packets alternating between sources 0 and 3.
    do_reset(2);
    for (int r = 0; r < 3; r++) begin
      push_pkt(0, 1);
      push_pkt(3, 1);
    end
    drain("single_drain", 100);
    check("single_len", DW'(log_src.size()), DW'(6));
    for (int k = 0; k < 6; k++) begin
      check("single_src", DW'(log_at(k)), DW'((k % 2 == 0) ? 0 : 3));
      if (k > 0 && k < log_cyc.size())
        check("single_gap", DW'(log_cyc[k] - log_cyc[k-1]), DW'(2));
    end

    // Reset during beat 2 of a 4-beat packet from source 1; source 2 pending.
    do_reset(2);
    push_pkt(1, 4);
    push_pkt(2, 1);
    step();
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    q_head[1] = q_tail[1];
    mark = log_src.size();
    check("rstmid_out_valid", DW'(out_valid), DW'(0));
    check("rstmid_busy", DW'(busy), DW'(0));
    step();
    check("rstmid_idle", DW'(s_busy), DW'(0));
    step();
    check("rstmid_grant2", DW'(s_in_ready), DW'(4'b0100));
    drain("rstmid_drain", 50);
    check("rstmid_len", DW'(log_src.size()), DW'(mark + 1));
    check("rstmid_first_src", DW'(log_at(mark)), DW'(2));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
